bin2bcd_seq: RTL

//   Sequential binary-to-BCD converter using iterative double-dabble, one bit per clock.

---
 rtl/bin2bcd_seq.sv | 111 +++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one binary bit per clock, start->done latency BIN_W+1 clocks.
// One conversion in flight at a time; start is ignored while busy, in DONE, and during the done pulse.
// The hundreds output is present only when BIN2BCD_HUNDREDS_EN is defined.
module bin2bcd_seq #(
    parameter int BIN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [7:0]       bcd,
    output logic             ovf
`ifdef BIN2BCD_HUNDREDS_EN
    ,
    output logic [3:0]       hundreds
`endif
);

    localparam int         SW       = 12 + BIN_W;
    localparam logic [3:0] CNT_LAST = 4'(BIN_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        state_q;
    logic [SW-1:0] scratch_q;
    logic [SW-1:0] corr;
    logic [SW-1:0] shift_d;
    logic [3:0]    cnt_q;
    logic          busy_q;
    logic          done_q;
    logic [7:0]    bcd_q;
    logic          ovf_q;
`ifdef BIN2BCD_HUNDREDS_EN
    logic [3:0]    hundreds_q;
`endif

    // Add-3 on every BCD nibble >= 5 in parallel, then shift; the binary field is never corrected.
    always_comb begin
        corr = scratch_q;
        for (int k = 0; k < 3; k++) begin
            if (scratch_q[BIN_W+4*k +: 4] >= 4'd5) begin
                corr[BIN_W+4*k +: 4] = scratch_q[BIN_W+4*k +: 4] + 4'd3;
            end
        end
        shift_d = corr << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            scratch_q  <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= 8'h00;
            ovf_q      <= 1'b0;
`ifdef BIN2BCD_HUNDREDS_EN
            hundreds_q <= 4'd0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // The cycle carrying the done pulse still counts as part of the previous conversion.
                    if (start && !done_q) begin
                        scratch_q <= {12'b0, bin};
                        cnt_q     <= 4'd0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    scratch_q <= shift_d;
                    cnt_q     <= (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
                    if (cnt_q == CNT_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bcd_q      <= scratch_q[BIN_W +: 8];
                    ovf_q      <= |scratch_q[BIN_W+8 +: 4];
`ifdef BIN2BCD_HUNDREDS_EN
                    hundreds_q <= scratch_q[BIN_W+8 +: 4];
`endif
                    done_q     <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;
`ifdef BIN2BCD_HUNDREDS_EN
    assign hundreds = hundreds_q;
`endif

endmodule
